// File: rtl/sha_hex_display_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sha_hex_display_scanner
// Brief    : Captures a SHA-256 digest and scans it onto multiplexed hex digits.
// Revision : 1.0
// ============================================================================
module sha_hex_display_scanner #(
    parameter  int DATA_WIDTH  = 256,
    parameter  int NUM_DIGITS  = 8,
    parameter  int REFRESH_DIV = 50000,
    parameter  int PAGE_HOLD   = 100000000,
    localparam int NUM_PAGES   = DATA_WIDTH / (4 * NUM_DIGITS),
    localparam int PAGE_W      = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] digest,
    input  logic                  rounds_done,
    input  logic                  page_next,
    input  logic                  auto_mode,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  dp,
    output logic [PAGE_W-1:0]     page_idx
);

    localparam int DIG_W = $clog2(NUM_DIGITS);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int TMR_W = (PAGE_HOLD > 1) ? $clog2(PAGE_HOLD) : 1;
    localparam int NIB_W = $clog2(DATA_WIDTH / 4);

    logic                  r_rd_q;
    logic                  r_shown;
    logic [DATA_WIDTH-1:0] r_shadow;
    logic [REF_W-1:0]      r_ref_cnt;
    logic [DIG_W-1:0]      r_digit;
    logic [PAGE_W-1:0]     r_page;
    logic [TMR_W-1:0]      r_timer;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_dp;

    logic                  w_cap;
    logic                  w_adv;
    logic [NIB_W-1:0]      w_nib_idx;
    logic [3:0]            w_nibble;
    logic [6:0]            w_seg_dec;

    assign w_cap = rounds_done & ~r_rd_q;
    assign w_adv = page_next | (auto_mode & (r_timer == TMR_W'(PAGE_HOLD - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_q   <= 1'b0;
            r_shown  <= 1'b0;
            r_shadow <= '0;
        end else begin
            r_rd_q <= rounds_done;
            if (w_cap) begin
                r_shadow <= digest;
                r_shown  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt <= '0;
            r_digit   <= '0;
        end else if (r_ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
            r_ref_cnt <= '0;
            r_digit   <= (r_digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_digit + 1'b1;
        end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    generate
        if (NUM_PAGES > 1) begin : g_multi_page
            // A fresh capture always restarts at page 0, overriding any advance.
            always_ff @(posedge clk) begin
                if (rst || w_cap) begin
                    r_page  <= '0;
                    r_timer <= '0;
                end else if (r_shown && w_adv) begin
                    r_page  <= (r_page == PAGE_W'(NUM_PAGES - 1)) ? '0 : r_page + 1'b1;
                    r_timer <= '0;
                end else if (r_shown && auto_mode) begin
                    r_timer <= r_timer + 1'b1;
                end else begin
                    r_timer <= '0;
                end
            end
        end else begin : g_single_page
            always_ff @(posedge clk) begin
                r_page  <= '0;
                r_timer <= '0;
            end
        end
    endgenerate

    always_comb begin
        w_nib_idx = NIB_W'((NUM_PAGES - 1 - int'(r_page)) * NUM_DIGITS + int'(r_digit));
        w_nibble  = r_shadow[{w_nib_idx, 2'b00} +: 4];
        w_seg_dec = 7'h7F;
        case (w_nibble)
            4'h0: w_seg_dec = 7'h40;
            4'h1: w_seg_dec = 7'h79;
            4'h2: w_seg_dec = 7'h24;
            4'h3: w_seg_dec = 7'h30;
            4'h4: w_seg_dec = 7'h19;
            4'h5: w_seg_dec = 7'h12;
            4'h6: w_seg_dec = 7'h02;
            4'h7: w_seg_dec = 7'h78;
            4'h8: w_seg_dec = 7'h00;
            4'h9: w_seg_dec = 7'h10;
            4'hA: w_seg_dec = 7'h08;
            4'hB: w_seg_dec = 7'h03;
            4'hC: w_seg_dec = 7'h46;
            4'hD: w_seg_dec = 7'h21;
            4'hE: w_seg_dec = 7'h06;
            default: w_seg_dec = 7'h0E;
        endcase
    end

    // seg/an/dp share one register stage so only a single digit is ever lit.
    always_ff @(posedge clk) begin
        if (rst || !r_shown) begin
            r_seg <= 7'h7F;
            r_an  <= '1;
            r_dp  <= 1'b1;
        end else begin
            r_seg <= w_seg_dec;
            r_an  <= ~(NUM_DIGITS'(1) << r_digit);
            r_dp  <= ~((r_page == '0) && (r_digit == DIG_W'(NUM_DIGITS - 1)));
        end
    end

    assign seg      = r_seg;
    assign an       = r_an;
    assign dp       = r_dp;
    assign page_idx = r_page;

endmodule
`default_nettype wire
